// File: rtl/pattern_scan_ctrl.sv
// Programmable serial-pattern scan controller: configurable pattern/length/overlap,
// run control with start/abort, per-hit match pulse, saturating hit count and limit-driven done.
module pattern_scan_ctrl #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             start,
    input  logic             abort,
    input  logic             din,
    input  logic             din_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] PAT_W_LEN = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t             state_r;
    state_t             state_s;
    logic [PAT_W-1:0]   pattern_r;
    logic [LEN_W-1:0]   len_r;
    logic               overlap_r;
    logic [CNT_W-1:0]   limit_r;
    logic               cfg_loaded_r;
    logic [PAT_W-2:0]   hist_r;
    logic [LEN_W-1:0]   fill_r;
    logic               match_r;
    logic [CNT_W-1:0]   count_r;
    logic               busy_r;
    logic               done_r;
    logic               cfg_ready_r;
    logic               cfg_err_r;

    logic               cfg_hs_s;
    logic               len_ok_s;
    logic               start_ok_s;
    logic               sample_s;
    logic [PAT_W-1:0]   window_s;
    logic [PAT_W-1:0]   mask_s;
    logic               fill_full_s;
    logic               hit_s;
    logic [CNT_W-1:0]   count_inc_s;
    logic               limit_hit_s;

    // Scan datapath decode: handshake qualification, window compare and hit detection
    always_comb begin
        cfg_hs_s    = cfg_valid && (state_r != ST_RUN);
        len_ok_s    = (cfg_len >= LEN_W'(2)) && (cfg_len <= PAT_W_LEN);
        start_ok_s  = start && cfg_loaded_r && !cfg_valid && (state_r != ST_RUN);
        sample_s    = (state_r == ST_RUN) && !abort && din_valid;
        window_s    = {hist_r, din};
        mask_s      = {PAT_W{1'b0}};
        for (int i = 0; i < PAT_W; i++) begin
            mask_s[i] = (i < int'(len_r));
        end
        // a hit needs len valid samples since start or since the last non-overlapping hit
        fill_full_s = (({1'b0, fill_r} + (LEN_W+1)'(1)) >= {1'b0, len_r});
        hit_s       = sample_s && (((window_s ^ pattern_r) & mask_s) == {PAT_W{1'b0}}) && fill_full_s;
        if (count_r == CNT_MAX) begin
            count_inc_s = count_r;
        end else begin
            count_inc_s = count_r + CNT_W'(1);
        end
        limit_hit_s = hit_s && (limit_r != {CNT_W{1'b0}}) && (count_inc_s == limit_r);
    end

    // Next-state logic; abort outranks config, which outranks start
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (limit_hit_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (cfg_hs_s && len_ok_s) begin
                    state_s = ST_IDLE;
                end else if (start_ok_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Config shadow, scan history/fill, hit counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_r    <= {PAT_W{1'b0}};
            len_r        <= {LEN_W{1'b0}};
            overlap_r    <= 1'b0;
            limit_r      <= {CNT_W{1'b0}};
            cfg_loaded_r <= 1'b0;
            hist_r       <= {(PAT_W-1){1'b0}};
            fill_r       <= {LEN_W{1'b0}};
            match_r      <= 1'b0;
            count_r      <= {CNT_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            cfg_ready_r  <= 1'b1;
            cfg_err_r    <= 1'b0;
        end else begin
            match_r     <= hit_s;
            cfg_err_r   <= cfg_hs_s && !len_ok_s;
            busy_r      <= (state_s == ST_RUN);
            done_r      <= (state_s == ST_DONE);
            cfg_ready_r <= (state_s != ST_RUN);
            if (cfg_hs_s && len_ok_s) begin
                pattern_r    <= cfg_pattern;
                len_r        <= cfg_len;
                overlap_r    <= cfg_overlap;
                limit_r      <= cfg_limit;
                cfg_loaded_r <= 1'b1;
            end
            if (start_ok_s) begin
                count_r <= {CNT_W{1'b0}};
                hist_r  <= {(PAT_W-1){1'b0}};
                fill_r  <= {LEN_W{1'b0}};
            end else if (sample_s) begin
                hist_r <= window_s[PAT_W-2:0];
                if (hit_s) begin
                    count_r <= count_inc_s;
                end
                if (hit_s && !overlap_r) begin
                    fill_r <= {LEN_W{1'b0}};
                end else if (fill_r != PAT_W_LEN) begin
                    fill_r <= fill_r + LEN_W'(1);
                end
            end
        end
    end

    assign cfg_ready   = cfg_ready_r;
    assign match       = match_r;
    assign match_count = count_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: stimulus pushes expected match/cfg_err events,
// a negedge monitor pops and compares them; directed state checks at key points.
module tb_pattern_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_pattern = 8'd0;
    logic [3:0] cfg_len = 4'd0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_limit = 8'd0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       match;
    logic [7:0] match_count;
    logic       busy;
    logic       done;
    logic       cfg_err;

    always #5 clk = ~clk;

    pattern_scan_ctrl #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_limit(cfg_limit), .start(start), .abort(abort), .din(din),
        .din_valid(din_valid), .match(match), .match_count(match_count),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // waits for the monitor to drain this cycle's event, then checks status outputs
    task automatic check_state(string tag, bit eb, bit ed, bit er, int ec);
        @(negedge clk);
        #1;
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
        chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(er));
        chk({tag, ".count"}, 32'(match_count), 32'(ec));
        chk({tag, ".pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic cfg(logic [7:0] pat, logic [3:0] len, bit ov, logic [7:0] lim, bit exp_err);
        if (exp_err) exp_q.push_back('{1'b1, 8'd0});
        cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_limit = lim;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic send(bit d, bit v, bit ab, bit exp_hit, int exp_cnt);
        if (exp_hit) exp_q.push_back('{1'b0, 8'(exp_cnt)});
        din = d; din_valid = v; abort = ab;
        step();
        din_valid = 1'b0; abort = 1'b0;
    endtask

    // Monitor: every match/cfg_err pulse must consume the next expected event
    always @(negedge clk) begin
        exp_t e;
        if (match === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_match: count %0d, no event required", match_count);
            end else begin
                e = exp_q.pop_front();
                if (e.is_err || (match_count !== e.cnt)) begin
                    n_err++;
                    $display("FAIL match_event: got match count %0d, required %s count %0d",
                             match_count, e.is_err ? "cfg_err" : "match", e.cnt);
                end
            end
        end
        if (cfg_err === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_cfg_err: got cfg_err 1, no event required");
            end else begin
                e = exp_q.pop_front();
                if (!e.is_err) begin
                    n_err++;
                    $display("FAIL cfg_err_event: got cfg_err, required match count %0d", e.cnt);
                end
            end
        end
    end

    initial begin
        step();
        step();
        reset = 1'b0;
        check_state("reset", 1'b0, 1'b0, 1'b1, 0);
        chk("reset.match", 32'(match), 32'd0);
        chk("reset.cfg_err", 32'(cfg_err), 32'd0);

        // overlapping 0110, limit 2
        cfg(8'b0110, 4'd4, 1'b1, 8'd2, 1'b0);
        check_state("t1_cfg", 1'b0, 1'b0, 1'b1, 0);
        do_start();
        check_state("t1_start", 1'b1, 1'b0, 1'b0, 0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 0);
        send(1'b0, 1'b1, 1'b0, 1'b1, 1);
        send(1'b1, 1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 0);
        send(1'b0, 1'b1, 1'b0, 1'b1, 2);
        check_state("t1_done", 1'b0, 1'b1, 1'b1, 2);

        // non-overlapping, unlimited; second window match lacks fill
        cfg(8'b0110, 4'd4, 1'b0, 8'd0, 1'b0);
        check_state("t2_cfg", 1'b0, 1'b0, 1'b1, 2);
        do_start();
        check_state("t2_start", 1'b1, 1'b0, 1'b0, 0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 0);
        send(1'b0, 1'b1, 1'b0, 1'b1, 1);
        send(1'b1, 1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 0);
        check_state("t2_run", 1'b1, 1'b0, 1'b0, 1);
        send(1'b0, 1'b0, 1'b1, 1'b0, 0);
        check_state("t2_abort", 1'b0, 1'b0, 1'b1, 1);

        // illegal lengths from reset
        do_reset();
        cfg(8'b0000_0011, 4'd1, 1'b1, 8'd0, 1'b1);
        check_state("t3_len1", 1'b0, 1'b0, 1'b1, 0);
        do_start();
        check_state("t3_start", 1'b0, 1'b0, 1'b1, 0);
        cfg(8'b0000_0011, 4'd9, 1'b1, 8'd0, 1'b1);
        do_start();
        check_state("t3_len9", 1'b0, 1'b0, 1'b1, 0);

        // gapped 101, then abort coincident with a hit
        cfg(8'b101, 4'd3, 1'b1, 8'd0, 1'b0);
        do_start();
        send(1'b1, 1'b1, 1'b0, 1'b0, 0);
        send(1'b0, 1'b0, 1'b0, 1'b0, 0);
        send(1'b0, 1'b0, 1'b0, 1'b0, 0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 1'b0, 1'b0, 1'b0, 0);
        send(1'b1, 1'b0, 1'b0, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 1'b1, 1);
        check_state("t4_gap", 1'b1, 1'b0, 1'b0, 1);
        send(1'b0, 1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 1'b1, 1'b1, 1'b0, 0);
        check_state("t4_abort", 1'b0, 1'b0, 1'b1, 1);

        // saturation with pattern 11
        cfg(8'b11, 4'd2, 1'b1, 8'd0, 1'b0);
        do_start();
        for (int k = 1; k <= 300; k++) begin
            send(1'b1, 1'b1, 1'b0, k >= 2, (k - 1 > 255) ? 255 : k - 1);
            chk("t5_no_done", 32'(done), 32'd0);
        end
        check_state("t5_sat", 1'b1, 1'b0, 1'b0, 255);
        send(1'b0, 1'b0, 1'b1, 1'b0, 0);

        // restart from DONE, then reset mid-run
        cfg(8'b11, 4'd2, 1'b1, 8'd1, 1'b0);
        do_start();
        send(1'b1, 1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 1'b1, 1);
        check_state("t6_done", 1'b0, 1'b1, 1'b1, 1);
        do_start();
        check_state("t6_restart", 1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 0);
        do_reset();
        check_state("t6_reset", 1'b0, 1'b0, 1'b1, 0);
        chk("t6_reset.match", 32'(match), 32'd0);
        chk("t6_reset.cfg_err", 32'(cfg_err), 32'd0);
        do_start();
        check_state("t6_start_noconfig", 1'b0, 1'b0, 1'b1, 0);
        cfg_valid = 1'b1; start = 1'b1;
        cfg_pattern = 8'b11; cfg_len = 4'd2; cfg_overlap = 1'b1; cfg_limit = 8'd0;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        check_state("t6_cfg_and_start", 1'b0, 1'b0, 1'b1, 0);
        do_start();
        check_state("t6_start", 1'b1, 1'b0, 1'b0, 0);
        send(1'b0, 1'b0, 1'b1, 1'b0, 0);
        check_state("t6_end", 1'b0, 1'b0, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
